// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage in front of the cpu decode/execute core. Owns the
// program counter, issues word reads to instruction memory over a req/ack
// handshake, buffers returned words in a small prefetch FIFO and presents
// them, tagged with their address, to the consumer over valid/ready.
// A branch redirect flushes the FIFO and restarts fetching at the new address.
//
// Parameters:
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   ADDR_W    address width
//   DATA_W    instruction width
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   synchronous, active-high
//   mem_req        out  read request, held until mem_ack
//   mem_addr       out  word address, stable while mem_req=1
//   mem_ack        in   read complete, mem_rdata valid this cycle
//   mem_rdata      in   returned instruction word
//   redirect       in   one-cycle pulse: branch taken
//   redirect_addr  in   new fetch address, sampled with redirect
//   instr_valid    out  instr_data/instr_pc hold a word
//   instr_ready    in   consumer accepts the word when both are high
//   instr_data     out  FIFO head instruction
//   instr_pc       out  address of instr_data
//   empty          out  FIFO occupancy is 0
//
// Optional feature macro: FETCH_BYPASS_EN
//   When defined, a word acked into an empty, non-flushing FIFO is driven
//   straight onto instr_* in the ack cycle; if the consumer takes it then,
//   it is never written into the FIFO.
//
// Handshake semantics: a word moves from producer to consumer on every rising
// edge where valid and ready are both 1; valid never depends on ready, and the
// presented word stays unchanged until it is taken or a redirect flushes it.
// The memory side follows the same rule with mem_req/mem_ack: mem_addr is
// held for as long as mem_req is 1 and the transfer happens on the ack edge.
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int unsigned        DEPTH    = 4,
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // IDLE : nothing outstanding
   // REQ  : request outstanding, its data will be kept
   // DRAIN: request outstanding, but a redirect made its data stale
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0] fifo_data_q [DEPTH];
   logic [DATA_W-1:0] fifo_data_d [DEPTH];
   logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
   logic [ADDR_W-1:0] fifo_pc_d   [DEPTH];

   logic head_valid;
   logic acked;
   logic bypass_take;
   logic fifo_push;
   logic fifo_pop;

   // Only an ack in REQ carries a word worth keeping; DRAIN acks are stale.
   assign head_valid = (count_q != '0);
   assign acked      = (state_q == S_REQ) && mem_ack;

   // ---------------------------------------------------------------------------
   // Consumer-side outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      instr_valid = head_valid;
      instr_data  = head_valid ? fifo_data_q[rd_ptr_q] : '0;
      instr_pc    = head_valid ? fifo_pc_q[rd_ptr_q]   : '0;
      bypass_take = 1'b0;
`ifdef FETCH_BYPASS_EN
      // Empty FIFO and no flush this cycle: show the returning word directly.
      if (!head_valid && acked && !redirect) begin
         instr_valid = 1'b1;
         instr_data  = mem_rdata;
         instr_pc    = mem_addr_q;
         bypass_take = instr_ready;
      end
`endif
   end

   assign fifo_pop  = head_valid && instr_ready;
   // A word taken through the bypass path never occupies a FIFO slot.
   assign fifo_push = acked && !redirect && !bypass_take;

   // ---------------------------------------------------------------------------
   // FIFO storage, pointers and occupancy
   // ---------------------------------------------------------------------------
   always_comb begin
      fifo_data_d = fifo_data_q;
      fifo_pc_d   = fifo_pc_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;

      if (redirect) begin
         // Flush wins over any push or pop in the same cycle; a word popped
         // now still counts as consumed by the downstream stage.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (fifo_push) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_pc_d[wr_ptr_q]   = mem_addr_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      end
   end

   // ---------------------------------------------------------------------------
   // Fetch FSM: next state, pc and request address
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_addr_d = mem_addr_q;

      unique case (state_q)
         S_IDLE: begin
            if (redirect) begin
               pc_d    = redirect_addr;
               state_d = S_REQ;
            end else if (count_q < FULL_CNT) begin
               state_d = S_REQ;
            end
            // No request is outstanding, so the address may follow pc freely.
            mem_addr_d = pc_d;
         end

         S_REQ: begin
            if (redirect) begin
               pc_d = redirect_addr;
               if (mem_ack) begin
                  // The acked word is dropped; restart right away at the target.
                  mem_addr_d = redirect_addr;
               end else begin
                  // Address must stay put until the ack; wait it out in DRAIN.
                  state_d = S_DRAIN;
               end
            end else if (mem_ack) begin
               pc_d       = pc_q + ADDR_W'(1);
               mem_addr_d = pc_d;
               // Keep streaming only if the next word is guaranteed a slot.
               state_d    = (count_d < FULL_CNT) ? S_REQ : S_IDLE;
            end
         end

         S_DRAIN: begin
            if (redirect) begin
               pc_d = redirect_addr;
            end
            if (mem_ack) begin
               // Stale word discarded; fetch the most recent redirect target.
               // FIFO is empty here, so there is always room.
               state_d    = S_REQ;
               mem_addr_d = pc_d;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         mem_addr_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_addr_q <= mem_addr_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Storage is never read while unoccupied, so it needs no reset.
   always_ff @(posedge clock) begin
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
   end

   assign mem_req  = (state_q != S_IDLE);
   assign mem_addr = mem_addr_q;
   assign empty    = (count_q == '0);

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Bench for instr_fetch. A memory responder returns addr ^ 0xA5A5A5A5 after a
// configurable latency. The reference model is the program-order rule: every
// consumed word must be the successor of the previously consumed one, except
// that after a redirect the next consumed word is the redirect target; after
// reset it is RESET_PC. A monitor pops the expected address from exp_q on
// every valid&ready and pushes its successor.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] KEY      = 32'hA5A5A5A5;
`ifdef FETCH_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   // clock / reset
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_pc;
   logic              empty;

   instr_fetch #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .RESET_PC (RESET_PC)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_data    (instr_data),
      .instr_pc      (instr_pc),
      .empty         (empty)
   );

   // scoreboard state
   logic [ADDR_W-1:0] exp_q[$];
   int tests_run    = 0;
   int tests_failed = 0;
   int consumed     = 0;
   int ack_cnt      = 0;
   int lat_min      = 0;
   int lat_max      = 0;
   int wait_cnt     = -1;
   logic [31:0] req_addr = '0;
   logic [31:0] prev_pc  = '0;
   logic        saw_wrap = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // driver tasks (called at a falling edge)
   task automatic do_redirect(input logic [31:0] addr);
      redirect      = 1'b1;
      redirect_addr = addr;
      @(negedge clock);
      redirect      = 1'b0;
   endtask

   // memory responder: drives at the falling edge
   initial begin : responder
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clock);
         if (reset || !mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = -1;
         end else begin
            if (wait_cnt < 0) begin
               wait_cnt = int'($urandom_range(lat_max, lat_min));
               req_addr = mem_addr;
            end
            if (wait_cnt == 0) begin
               check("addr_stable", mem_addr, req_addr);
               mem_ack   = 1'b1;
               mem_rdata = mem_addr ^ KEY;
               ack_cnt++;
               wait_cnt  = -1;
            end else begin
               mem_ack  = 1'b0;
               wait_cnt--;
            end
         end
      end
   end

   // monitor: samples 1 time unit before each rising edge
   initial begin : monitor
      logic [31:0] e;
      forever begin
         @(negedge clock);
         #4;
         if (reset) begin
            exp_q.delete();
            exp_q.push_back(RESET_PC);
         end else begin
            if (instr_valid && instr_ready) begin
               if (exp_q.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("FAIL sb_unexpected: got pc %0h expected nothing", instr_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_pc", instr_pc, e);
                  check("sb_data", instr_data, e ^ KEY);
                  exp_q.push_back(e + 32'd1);
               end
               if (prev_pc == 32'hFFFF_FFFF && instr_pc == 32'h0) saw_wrap = 1'b1;
               prev_pc = instr_pc;
               consumed++;
            end
            if (redirect) begin
               exp_q.delete();
               exp_q.push_back(redirect_addr);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   // main stimulus
   initial begin : main
      logic found;
      int   c0;
      reset         = 1'b1;
      redirect      = 1'b0;
      redirect_addr = '0;
      instr_ready   = 1'b0;

      // reset values
      repeat (3) @(negedge clock);
      #4;
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, RESET_PC);
      check("rst_valid", instr_valid, 0);
      check("rst_data", instr_data, 0);
      check("rst_pc", instr_pc, 0);
      check("rst_empty", empty, 1);

      // release; mem_req rises one cycle later. Consumer stalled.
      @(negedge clock);
      ack_cnt = 0;
      reset   = 1'b0;
      check("req_low_at_release", mem_req, 0);
      @(negedge clock);
      check("req_rise", mem_req, 1);
      check("first_addr", mem_addr, RESET_PC);

      // backpressure: exactly DEPTH words accepted
      repeat (20) @(negedge clock);
      #4;
      check("bp_acks", ack_cnt, DEPTH);
      check("bp_req", mem_req, 0);
      check("bp_valid", instr_valid, 1);
      check("bp_pc", instr_pc, 0);
      check("bp_empty", empty, 0);

      @(negedge clock);
      instr_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (mem_req) begin
            found = 1'b1;
            break;
         end
      end
      check("resume_seen", found, 1);
      check("resume_addr", mem_addr, DEPTH);

      // streaming throughput with single-cycle acks
      repeat (8) @(negedge clock);
      c0 = consumed;
      repeat (10) @(negedge clock);
      check("throughput", consumed - c0, 10);

      // redirect while a request waits 3 cycles for its ack
      lat_min = 3;
      lat_max = 3;
      do_redirect(32'h5);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (mem_req && mem_addr == 32'h5) begin
            found = 1'b1;
            break;
         end
         @(negedge clock);
      end
      check("req5_seen", found, 1);
      @(negedge clock);
      do_redirect(32'h100);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mem_req && mem_addr != 32'h5) begin
            found = 1'b1;
            break;
         end
         @(negedge clock);
      end
      check("redir_next_addr", mem_addr, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #4;
         if (mem_ack) begin
            found = 1'b1;
            break;
         end
         @(negedge clock);
      end
      check("redir_ack_seen", found, 1);
      check("fill_valid_ack_cycle", instr_valid, BYP);
      check("fill_empty_ack_cycle", empty, 1);
`ifdef FETCH_BYPASS_EN
      check("bypass_pc", instr_pc, 32'h100);
`else
      @(negedge clock);
      #4;
      check("fill_valid_next", instr_valid, 1);
      check("fill_pc_next", instr_pc, 32'h100);
`endif

      // redirect + ack + pop in the same cycle with two words buffered
      @(negedge clock);
      instr_ready = 1'b0;
      lat_min = 0;
      lat_max = 0;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (!mem_req) begin
            found = 1'b1;
            break;
         end
      end
      check("full_seen", found, 1);
      instr_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      redirect      = 1'b1;
      redirect_addr = 32'h40;
      #4;
      check("same_ack", mem_ack, 1);
      check("same_valid", instr_valid, 1);
      @(negedge clock);
      redirect = 1'b0;
      #4;
      check("same_valid_after", instr_valid, BYP);
      check("same_req_after", mem_req, 1);
      check("same_addr_after", mem_addr, 32'h40);
      check("same_empty_after", empty, 1);

      // address wrap
      @(negedge clock);
      do_redirect(32'hFFFF_FFFE);
      repeat (12) @(negedge clock);
      check("wrap_seen", saw_wrap, 1);

      // reset in the middle of an outstanding request
      lat_min = 3;
      lat_max = 3;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #4;
      check("rst_mid_req", mem_req, 0);
      check("rst_mid_valid", instr_valid, 0);
      check("rst_mid_empty", empty, 1);
      @(negedge clock);
      reset   = 1'b0;
      lat_min = 0;
      lat_max = 0;
      repeat (12) @(negedge clock);

      // randomized phase
      for (int i = 0; i < 500; i++) begin
         @(negedge clock);
         instr_ready = ($urandom_range(0, 3) != 0);
         if (i % 50 == 0) begin
            lat_min = 0;
            lat_max = int'($urandom_range(0, 3));
         end
         if (!redirect && $urandom_range(0, 15) == 0) begin
            redirect = 1'b1;
            if ($urandom_range(0, 1) == 0) redirect_addr = 32'($urandom_range(0, 255));
            else redirect_addr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         end else begin
            redirect = 1'b0;
         end
      end
      @(negedge clock);
      redirect = 1'b0;
      repeat (4) @(negedge clock);

      check("sb_depth", exp_q.size(), 1);
      check("progress", (consumed >= 200), 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
